// File: rtl/seg_scan_driver_pkg.sv
// Seven-segment code constants and segment bus layout shared by the scan driver.
package seg_scan_driver_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned SEG_DP = 7;

  // Segment bit order within the 7-bit code: {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F = 7'h71;

  // One bank's segment bus: {dp,g,f,e,d,c,b,a}
  typedef struct packed {
    logic             dp;
    logic [SEG_W-1:0] seg;
  } seg_bus_t;

endpackage

// File: rtl/seg_scan_driver_decode.sv
// Combinational hex digit to seven-segment code.
module seg7_decode
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0]       digit,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_0;
    unique case (digit)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      4'hF: seg_c = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Two-bank, 4-digit multiplexed seven-segment driver with frame-coherent
// shadow capture, dead time between digits, and per-digit dp/blank/blink.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned SCAN_HZ  = 1000,
  parameter int unsigned DEAD_CYC = 2000,
  parameter int unsigned BLINK_HZ = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_lo,
  input  logic [15:0] digits_hi,
  input  logic [7:0]  dp,
  input  logic [7:0]  blank,
  input  logic [7:0]  blink,
  output logic [3:0]  wei,
  output logic [7:0]  duan,
  output logic [7:0]  duan1,
  output logic        frame_tick
);

  localparam int unsigned DIV  = CLK_FREQ / SCAN_HZ;
  localparam int unsigned BDIV = CLK_FREQ / (2 * BLINK_HZ);
  localparam int unsigned PW   = (DIV  > 1) ? $clog2(DIV)  : 1;
  localparam int unsigned BW   = (BDIV > 1) ? $clog2(BDIV) : 1;

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [BW-1:0] bcnt;
  logic          phase;

  logic [15:0] sh_lo, sh_hi;
  logic [7:0]  sh_dp, sh_blank, sh_blink;

  logic             wrap_c, load_c, lit_c, dark_lo_c, dark_hi_c;
  logic [3:0]       nib_lo_c, nib_hi_c;
  logic [SEG_W-1:0] seg_lo_c, seg_hi_c;
  logic [3:0]       wei_c;
  seg_bus_t         bus_lo_c, bus_hi_c;

  assign wrap_c = (presc == PW'(DIV - 1));
  assign load_c = wrap_c && (idx == 2'd3);

  // Slot prescaler and digit index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (wrap_c) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Free-running blink phase, independent of scanning
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == BW'(BDIV - 1)) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt  <= bcnt + BW'(1);
    end
  end

  // Shadow registers load only when entering slot 0 so a frame never tears
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_lo    <= '0;
      sh_hi    <= '0;
      sh_dp    <= '0;
      sh_blank <= 8'hFF;
      sh_blink <= '0;
    end else if (load_c) begin
      sh_lo    <= digits_lo;
      sh_hi    <= digits_hi;
      sh_dp    <= dp;
      sh_blank <= blank;
      sh_blink <= blink;
    end
  end

  assign nib_lo_c = sh_lo[{idx, 2'b00} +: 4];
  assign nib_hi_c = sh_hi[{idx, 2'b00} +: 4];

  seg7_decode u_dec_lo (.digit(nib_lo_c), .seg_c(seg_lo_c));
  seg7_decode u_dec_hi (.digit(nib_hi_c), .seg_c(seg_hi_c));

  always_comb begin
    lit_c     = (presc >= PW'(DEAD_CYC));
    dark_lo_c = sh_blank[{1'b0, idx}] | (sh_blink[{1'b0, idx}] & phase);
    dark_hi_c = sh_blank[{1'b1, idx}] | (sh_blink[{1'b1, idx}] & phase);
    wei_c     = '0;
    bus_lo_c  = '0;
    bus_hi_c  = '0;
    if (lit_c) begin
      wei_c = 4'(1) << idx;
      if (!dark_lo_c) begin
        bus_lo_c.seg = seg_lo_c;
        bus_lo_c.dp  = sh_dp[{1'b0, idx}];
      end
      if (!dark_hi_c) begin
        bus_hi_c.seg = seg_hi_c;
        bus_hi_c.dp  = sh_dp[{1'b1, idx}];
      end
    end
  end

  // Registered pins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wei        <= '0;
      duan       <= '0;
      duan1      <= '0;
      frame_tick <= 1'b0;
    end else begin
      wei        <= wei_c;
      duan       <= bus_lo_c;
      duan1      <= bus_hi_c;
      frame_tick <= load_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench: directed scenarios plus random inputs, checked against
// a time-indexed reference model of the scan/shadow/blink rules.
module tb_seg_scan_driver;

  localparam int unsigned CLK_FREQ = 1000;
  localparam int unsigned SCAN_HZ  = 100;
  localparam int unsigned DEAD_CYC = 2;
  localparam int unsigned BLINK_HZ = 25;
  localparam int unsigned DIV      = CLK_FREQ / SCAN_HZ;
  localparam int unsigned BDIV     = CLK_FREQ / (2 * BLINK_HZ);
  localparam int unsigned FRAME    = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits_lo, digits_hi;
  logic [7:0]  dp, blank, blink;
  logic [3:0]  wei;
  logic [7:0]  duan, duan1;
  logic        frame_tick;

  seg_scan_driver #(
    .CLK_FREQ(CLK_FREQ), .SCAN_HZ(SCAN_HZ), .DEAD_CYC(DEAD_CYC), .BLINK_HZ(BLINK_HZ)
  ) dut (
    .clk(clk), .rst(rst), .digits_lo(digits_lo), .digits_hi(digits_hi),
    .dp(dp), .blank(blank), .blink(blink),
    .wei(wei), .duan(duan), .duan1(duan1), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int checks = 0;
  int errors = 0;

  // Model state: n = rising edges since reset release; shadow copy of inputs
  int          n;
  logic [15:0] m_lo, m_hi;
  logic [7:0]  m_dp, m_blank, m_blink;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h edge=%0d", tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0;
    m_lo = '0; m_hi = '0; m_dp = '0; m_blank = 8'hFF; m_blink = '0;
  endtask

  function automatic logic [7:0] bank_exp(input logic [15:0] d, input int slot,
                                          input int bit_i, input int ph);
    logic [3:0] nib;
    nib = 4'((d >> (slot * 4)) & 16'hF);
    if (m_blank[bit_i] || (m_blink[bit_i] && ph == 1)) return 8'h00;
    return {m_dp[bit_i], seg_tab[nib]};
  endfunction

  // One clock: pins after edge n reflect the counter state after edge n-1
  task automatic step();
    int m, slot, pos, ph;
    logic [7:0] e_wei, e_lo, e_hi, e_ft;
    @(posedge clk);
    n++;
    m    = n - 1;
    slot = (m / DIV) % 4;
    pos  = m % DIV;
    ph   = (m / BDIV) % 2;
    if (pos < DEAD_CYC) begin
      e_wei = 8'h0; e_lo = 8'h0; e_hi = 8'h0;
    end else begin
      e_wei = 8'(1 << slot);
      e_lo  = bank_exp(m_lo, slot, slot, ph);
      e_hi  = bank_exp(m_hi, slot, slot + 4, ph);
    end
    e_ft = (n % FRAME == 0) ? 8'h1 : 8'h0;
    if (n % FRAME == 0) begin
      m_lo = digits_lo; m_hi = digits_hi; m_dp = dp; m_blank = blank; m_blink = blink;
    end
    #1;
    chk("wei", 8'(wei), e_wei);
    chk("duan", duan, e_lo);
    chk("duan1", duan1, e_hi);
    chk("frame_tick", 8'(frame_tick), e_ft);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic rand_inputs();
    digits_lo = 16'($urandom);
    digits_hi = 16'($urandom);
    dp        = 8'($urandom);
    blank     = 8'($urandom & $urandom & $urandom);
    blink     = 8'($urandom & $urandom);
  endtask

  initial begin
    rst = 1'b0;
    digits_lo = '0; digits_hi = '0; dp = '0; blank = '0; blink = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wei", 8'(wei), 8'h0);
    chk("rst_duan", duan, 8'h0);
    chk("rst_duan1", duan1, 8'h0);
    chk("rst_ft", 8'(frame_tick), 8'h0);

    // Release; first frame dark, first load at edge 40
    digits_lo = 16'h3210; digits_hi = 16'h7654;
    @(negedge clk);
    rst = 1'b1;
    run(FRAME);
    run(FRAME);

    // Decimal points and hex letters
    dp = 8'h24; digits_lo = 16'hFEDC;
    run(FRAME);
    run(FRAME);

    // Mid-frame change must not tear: 1111 loads, 2222 arrives in slot 1
    digits_lo = 16'h1111; dp = 8'h00;
    run(FRAME - (n % FRAME));
    run(DIV + DIV / 2);
    digits_lo = 16'h2222;
    run(FRAME);
    run(FRAME);

    // Blink on low digit 0 across several blink phases
    blink = 8'h01; digits_lo = 16'h2228;
    run(6 * FRAME);

    // Random inputs changed at random moments, including mid-frame
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) rand_inputs();
      step();
    end

    // Async reset in the middle of slot 2
    while (!(((n / DIV) % 4 == 2) && (n % DIV == 5))) step();
    #2;
    rst = 1'b0;
    #1;
    chk("async_wei", 8'(wei), 8'h0);
    chk("async_duan", duan, 8'h0);
    chk("async_duan1", duan1, 8'h0);
    chk("async_ft", 8'(frame_tick), 8'h0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3 * FRAME; i++) begin
      if ($urandom_range(0, 7) == 0) rand_inputs();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Downstream display stage of the stopwatch. It consumes 8 hex/BCD digits from the timekeeping core and time-multiplexes them onto two 4-digit seven-segment banks. The two banks share a one-hot digit select `wei` and have separate segment buses `duan` (low bank) and `duan1` (high bank). Features: per-digit decimal point, blanking and blinking (for countdown set mode), frame-coherent input capture, and a ghost-suppression dead time between digits.

Parameters:
CLK_FREQ, 100_000_000, input clock frequency in Hz
SCAN_HZ, 1000, digit-slot rate in Hz; DIV = CLK_FREQ/SCAN_HZ cycles per slot
DEAD_CYC, 2000, cycles at the start of each slot with all outputs dark; must be < DIV
BLINK_HZ, 2, blink rate in Hz; phase toggles every CLK_FREQ/(2*BLINK_HZ) cycles

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
digits_lo  in  16  low-bank digits; nibble i = position i
digits_hi  in  16  high-bank digits; nibble i = position i
dp  in  8  decimal-point enables; bits 3:0 = low bank, bits 7:4 = high bank
blank  in  8  force-dark mask, same bit mapping as dp
blink  in  8  blink mask, same bit mapping as dp
wei  out  4  one-hot digit select, active-high, shared by both banks
duan  out  8  low-bank segments, active-high, {dp,g,f,e,d,c,b,a}
duan1  out  8  high-bank segments, same encoding
frame_tick  out  1  one-cycle pulse when the shadow registers load

Behaviour:
- Reset (rst=0, async):
  - wei=0, duan=0, duan1=0, frame_tick=0.
  - Prescaler=0, slot index=0, dead counter=0, blink phase=0.
  - Shadow digits=0, shadow dp=0, shadow blank=8'hFF (display dark until first load).
- Prescaler counts 0..DIV-1 and wraps. At DIV-1 the slot index advances 0→1→2→3→0.
- Shadow load:
  - Occurs on the prescaler-wrap cycle when index==3 (entering slot 0).
  - digits_lo/hi, dp, blank and blink are captured in that one cycle.
  - frame_tick=1 for exactly that cycle.
  - Input changes at any other time have no visible effect until the next load, so no tearing within a frame.
- Within slot i:
  - Prescaler 0..DEAD_CYC-1: wei=0 and duan=duan1=0.
  - Otherwise: wei=(1<<i); duan = decode(shadow_lo[i]) | dp bit; duan1 likewise for bank hi (bit i+4).
- Decode (bits g..a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - A=77, b=7C, C=39, d=5E, E=79, F=71
  - dp is bit 7.
- Masking:
  - A digit is dark (segments and dp = 0) if its shadow blank bit is set, or if its shadow blink bit is set while blink phase=1.
  - `wei` still asserts for a dark digit.
- Blink counter is free-running from reset and independent of the scan counters.
- All outputs are registered: one cycle of latency from internal counter state to pins, applied uniformly.
- Boundary cases:
  - Index wrap and shadow load coincide by design.
  - Blink toggle coinciding with a slot boundary: the new phase applies from that cycle.
  - Reset mid-slot returns everything to dark immediately (async) and restarts at slot 0 with shadow blank=FF.

Decomposition:
- Shared package: seven-segment code constants (SEG_0..SEG_F, SEG_DP bit index) and the segment bit-order definition.
- Natural sub-module: seg7_decode (combinational, 4-bit in → 7-bit out), instantiated twice (one per bank).
- Counters, shadow registers and masking stay in seg_scan_driver.

Test Plan:
1. Test parameters CLK_FREQ=1000, SCAN_HZ=100 (DIV=10), DEAD_CYC=2, BLINK_HZ=25 (toggle every 20 cycles). Hold rst=0, then release → wei=0, duan=0, duan1=0 through the first 40 cycles (shadow blank=FF); frame_tick pulses on cycle 40 after release.
2. digits_lo=16'h3210, digits_hi=16'h7654, blank=0, blink=0, dp=0 → in slot 0 after dead time: wei=0001, duan=3F, duan1=66. Slot 3: wei=1000, duan=4F, duan1=07. Each slot has 2 dark cycles then 8 lit cycles.
3. dp=8'h24, digits_lo=16'hFEDC → slot 2: duan=F9 (E with dp); slot 1: duan1=6D|80=ED for digit 5.
4. Change digits_lo mid-frame (slot 1) from 16'h1111 to 16'h2222 → slots 1–3 still show 06; 5B appears only after the next frame_tick.
5. blink=8'h01, digits_lo nibble0=8 → slot-0 duan alternates 7F / 00 with the blink phase; other digits are unaffected; wei stays 0001 in slot 0 throughout.
6. Assert rst=0 mid-slot 2 → wei, duan, duan1 go to 0 immediately (asynchronously). On release, scanning restarts at slot 0, dark until the next frame_tick.
